operand_memory_responder: RTL and testbench
===========================================

// Module: operand_memory_responder
// PURPOSE
//  Responder end of the operand fetch/store interface driven by the control matrix.
//  256x8 data memory; serves one outstanding read or write request at a time over a
//  valid/ready request channel and returns the result on a valid/ready response channel.
//  Sits between the control matrix and data storage; emulates memory wait states.
// PARAMETERS
//  ADDR_W        8   address width; depth = 2**ADDR_W
//  DATA_W        8   data width
//  READ_LATENCY  2   cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       responder can accept a request this cycle
//  req_write  in   1       1 = write req_wdata to req_addr, 0 = read req_addr
//  req_addr   in   ADDR_W  target address
//  req_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       requester consumes response this cycle
//  rsp_rdata  out  DATA_W  read data; for writes, the data written
//  rsp_addr   out  ADDR_W  echo of the accepted address
//  rsp_write  out  1       echo of the accepted req_write
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, while high): state=IDLE, wait counter=0, req_ready=0, rsp_valid=0,
//   rsp_rdata=0, rsp_addr=0, rsp_write=0, busy=0, all memory words cleared to 0.
//   req_ready rises on the first rising edge after reset deasserts.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. Accept = req_valid & req_ready at a rising edge. On accept,
//    latch addr/write/wdata; a write commits mem[addr] at the accept edge; load counter
//    with READ_LATENCY-1; go to WAIT.
//   WAIT: req_ready=0. Decrement each cycle; when counter==0, at that edge capture
//    rsp_rdata = mem[addr] (or wdata for writes), assert rsp_valid, go to RESP.
//    Accept at edge N => rsp_valid high after edge N+READ_LATENCY.
//   RESP: rsp_valid=1, rsp_* held stable until rsp_ready=1 at a rising edge; then
//    rsp_valid=0, go to IDLE. req_ready stays 0 in RESP (no overlap).
//  One outstanding request; max throughput one request per READ_LATENCY+2 cycles.
//  req_* changes while req_ready=0 are ignored; only values at accept are used.
//  Read after write to same address returns the new data (write commits first).
//  Addresses wrap naturally within ADDR_W; no out-of-range case exists.
//  rsp_ready high while rsp_valid low: ignored.
//  Reset mid-operation (WAIT or RESP): request abandoned, no response produced,
//   memory cleared, including a write committed earlier in that transaction.
//  READ_LATENCY outside 1..15: elaboration error.
// TESTING
//  1 Reset: assert reset mid-cycle -> all outputs 0 immediately; req_ready=1 one edge
//    after release; read of addr 0x55 returns 0x00.
//  2 Write 0xA5 to 0x10 then read 0x10 -> write rsp: rdata=0xA5, rsp_write=1, addr=0x10;
//    read rsp: rdata=0xA5, rsp_valid exactly 2 edges after read accept.
//  3 Response backpressure: rsp_ready low 5 cycles -> rsp_valid/rdata/addr stable,
//    req_ready=0 throughout; first cycle with rsp_ready=1 -> IDLE next edge.
//  4 Back-to-back: req_valid held high with 4 writes (0x00..0x03 <- 0x11..0x44) then
//    4 reads -> each accepted only in IDLE, reads return 0x11,0x22,0x33,0x44 in order.
//  5 Address wrap/extremes: write 0xFF<-0x7E, 0x00<-0x01 -> read 0xFF=0x7E, 0x00=0x01.
//  6 Reset during WAIT of write 0x3C->0x20 -> no rsp_valid; later read 0x20 = 0x00.
//    Repeat 2 with READ_LATENCY=1 and 15 to check latency counting.

Source files
------------

// File: rtl/operand_memory_responder.sv
// Responder for the operand fetch/store channel: a cleared-on-reset data memory that
// serves one read or write at a time, inserting READ_LATENCY wait states before responding.
module operand_memory_responder #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_write,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
         $error("operand_memory_responder: READ_LATENCY must be within 1..15");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_r;
   logic [3:0]        wait_cnt_r;
   logic [ADDR_W-1:0] addr_r;
   logic              write_r;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic              accept_s;

   // Handshake completes only in IDLE, so requests presented while busy are ignored.
   assign accept_s = (state_r == IDLE) && req_valid && req_ready;

   // Request/response sequencing with registered handshake and echo outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         wait_cnt_r <= 4'd0;
         addr_r     <= '0;
         write_r    <= 1'b0;
         wdata_r    <= '0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_addr   <= '0;
         rsp_write  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  addr_r     <= req_addr;
                  write_r    <= req_write;
                  wdata_r    <= req_wdata;
                  wait_cnt_r <= 4'(READ_LATENCY - 1);
                  req_ready  <= 1'b0;
                  busy       <= 1'b1;
                  state_r    <= WAIT;
               end else begin
                  req_ready  <= 1'b1;
               end
            end
            WAIT: begin
               if (wait_cnt_r == 4'd0) begin
                  rsp_rdata <= write_r ? wdata_r : mem_r[addr_r];
                  rsp_addr  <= addr_r;
                  rsp_write <= write_r;
                  rsp_valid <= 1'b1;
                  state_r   <= RESP;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  rsp_valid <= 1'b1;
               end
            end
            default: begin
               req_ready <= 1'b0;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   // Storage: writes commit at the accept edge so a following read sees the new data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (accept_s && req_write) begin
         mem_r[req_addr] <= req_wdata;
      end
   end

endmodule

// File: tb/tb_operand_memory_responder.sv
// Randomized bench for operand_memory_responder at latencies 2, 1 and 15, checked every
// cycle against a timeline model plus literal expectations for the directed scenarios.
module tb_operand_memory_responder;

   logic       clk = 1'b0;
   logic [2:0] rst, req_valid, req_write, rsp_ready;
   logic [7:0] req_addr [3];
   logic [7:0] req_wdata [3];
   logic [2:0] req_ready, rsp_valid, rsp_write, busy;
   logic [7:0] rsp_rdata [3];
   logic [7:0] rsp_addr [3];

   always #5 clk = ~clk;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      operand_memory_responder #(
         .ADDR_W(8), .DATA_W(8), .READ_LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) u_dut (
         .clock(clk), .reset(rst[g]),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
         .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
         .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
         .rsp_addr(rsp_addr[g]), .rsp_write(rsp_write[g]), .busy(busy[g])
      );
   end

   int checks = 0;
   int failures = 0;

   // Directed expectations posted by the stimulus, evaluated by the compare process.
   string       dir_nm  [64];
   int          dir_k   [64];
   logic [31:0] dir_act [64];
   logic [31:0] dir_exp [64];
   int          dir_wr = 0;
   int          dir_rd = 0;

   task automatic post(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      dir_nm[dir_wr % 64]  = nm;
      dir_k[dir_wr % 64]   = k;
      dir_act[dir_wr % 64] = act;
      dir_exp[dir_wr % 64] = exp;
      dir_wr++;
   endtask

   task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[inst %0d] got=%0h want=%0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Model: memory contents and a timeline of when each response becomes visible.
   logic [7:0] m_mem [3][256];
   logic       m_ready [3];
   logic       m_pend  [3];
   logic       m_vis   [3];
   int         m_rem   [3];
   logic [7:0] m_rdata [3];
   logic [7:0] m_addr  [3];
   logic       m_wr    [3];
   logic [2:0] s_rst = 3'b111;
   logic [2:0] s_req_valid = 3'b000, s_req_write = 3'b000, s_rsp_ready = 3'b000;
   logic [7:0] s_req_addr  [3];
   logic [7:0] s_req_wdata [3];

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst[k] || s_rst[k]) begin
            m_ready[k] = 1'b0; m_pend[k] = 1'b0; m_vis[k] = 1'b0; m_rem[k] = 0;
            m_rdata[k] = 8'h00; m_addr[k] = 8'h00; m_wr[k] = 1'b0;
            for (int i = 0; i < 256; i++) m_mem[k][i] = 8'h00;
         end else if (m_vis[k]) begin
            if (s_rsp_ready[k]) begin
               m_vis[k]   = 1'b0;
               m_ready[k] = 1'b1;
            end
         end else if (m_pend[k]) begin
            m_rem[k] = m_rem[k] - 1;
            if (m_rem[k] == 0) begin
               m_pend[k] = 1'b0;
               m_vis[k]  = 1'b1;
            end
         end else if (!m_ready[k]) begin
            m_ready[k] = 1'b1;
         end else if (s_req_valid[k]) begin
            if (s_req_write[k]) m_mem[k][s_req_addr[k]] = s_req_wdata[k];
            m_rdata[k] = m_mem[k][s_req_addr[k]];
            m_addr[k]  = s_req_addr[k];
            m_wr[k]    = s_req_write[k];
            m_ready[k] = 1'b0;
            m_pend[k]  = 1'b1;
            m_rem[k]   = lat_of(k);
         end
         cmp("req_ready", k, 32'(req_ready[k]), 32'(m_ready[k]));
         cmp("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_vis[k]));
         cmp("busy", k, 32'(busy[k]), 32'(m_pend[k] | m_vis[k]));
         if (m_vis[k] || rst[k]) begin
            cmp("rsp_rdata", k, 32'(rsp_rdata[k]), 32'(m_rdata[k]));
            cmp("rsp_addr", k, 32'(rsp_addr[k]), 32'(m_addr[k]));
            cmp("rsp_write", k, 32'(rsp_write[k]), 32'(m_wr[k]));
         end
         s_rst[k]       = rst[k];
         s_req_valid[k] = req_valid[k];
         s_req_write[k] = req_write[k];
         s_req_addr[k]  = req_addr[k];
         s_req_wdata[k] = req_wdata[k];
         s_rsp_ready[k] = rsp_ready[k];
      end
      while (dir_rd < dir_wr) begin
         cmp(dir_nm[dir_rd % 64], dir_k[dir_rd % 64], dir_act[dir_rd % 64], dir_exp[dir_rd % 64]);
         dir_rd++;
      end
   end

   // One transaction; returns the response as first seen and the accept-to-valid latency.
   task automatic txn(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input int stall, input bit hold, input bit chk_stall, input logic [7:0] exp_rd,
                      output logic [7:0] rd, output logic [7:0] ra, output logic rw, output int lat);
      int n;
      req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d;
      n = 0;
      while (!req_ready[k] && n < 100) begin
         rsp_ready[k] = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) post(k, "accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (!hold) begin
         req_valid[k] = 1'b0; req_write[k] = 1'($urandom_range(0, 1));
         req_addr[k] = 8'($urandom); req_wdata[k] = 8'($urandom);
      end
      lat = 0;
      while (!rsp_valid[k] && lat < 100) begin
         rsp_ready[k] = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 100) post(k, "rsp_timeout", 32'd0, 32'd1);
      rd = rsp_rdata[k]; ra = rsp_addr[k]; rw = rsp_write[k];
      rsp_ready[k] = 1'b0;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         if (chk_stall) begin
            post(k, "stall_valid", 32'(rsp_valid[k]), 32'd1);
            post(k, "stall_rdata", 32'(rsp_rdata[k]), 32'(exp_rd));
            post(k, "stall_addr", 32'(rsp_addr[k]), 32'(a));
            post(k, "stall_ready", 32'(req_ready[k]), 32'd0);
         end
      end
      rsp_ready[k] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[k] = 1'b0;
   endtask

   task automatic run_inst(input int k, input int nrand);
      logic [7:0] rd, ra;
      logic       rw;
      int         lat;
      logic [7:0] tbl [4];
      tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
      // Release, then a mid-cycle reset that must clear outputs immediately.
      @(posedge clk); #1; rst[k] = 1'b0;
      post(k, "ready_at_release", 32'(req_ready[k]), 32'd0);
      @(posedge clk); #1;
      post(k, "ready_after_edge", 32'(req_ready[k]), 32'd1);
      #1 rst[k] = 1'b1;
      #1 post(k, "async_ready", 32'(req_ready[k]), 32'd0);
      @(posedge clk); #1; rst[k] = 1'b0;
      @(posedge clk); #1;
      post(k, "ready_rerelease", 32'(req_ready[k]), 32'd1);
      txn(k, 1'b0, 8'h55, 8'h00, 0, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      post(k, "cleared_read", 32'(rd), 32'h00);
      // Write then read back.
      txn(k, 1'b1, 8'h10, 8'hA5, 0, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      post(k, "wr_rdata", 32'(rd), 32'hA5);
      post(k, "wr_write", 32'(rw), 32'd1);
      post(k, "wr_addr", 32'(ra), 32'h10);
      txn(k, 1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      post(k, "rd_rdata", 32'(rd), 32'hA5);
      post(k, "rd_write", 32'(rw), 32'd0);
      post(k, "rd_latency", 32'(lat), 32'(lat_of(k)));
      // Backpressure for five cycles.
      txn(k, 1'b0, 8'h10, 8'h00, 5, 1'b0, 1'b1, 8'hA5, rd, ra, rw, lat);
      post(k, "idle_busy", 32'(busy[k]), 32'd0);
      post(k, "idle_ready", 32'(req_ready[k]), 32'd1);
      // Back-to-back with req_valid held high.
      for (int i = 0; i < 4; i++)
         txn(k, 1'b1, 8'(i), tbl[i], 0, 1'b1, 1'b0, 8'h00, rd, ra, rw, lat);
      for (int i = 0; i < 4; i++) begin
         txn(k, 1'b0, 8'(i), 8'h00, 0, 1'b1, 1'b0, 8'h00, rd, ra, rw, lat);
         post(k, "b2b_rdata", 32'(rd), 32'(tbl[i]));
      end
      req_valid[k] = 1'b0;
      // Address extremes.
      txn(k, 1'b1, 8'hFF, 8'h7E, 0, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      txn(k, 1'b1, 8'h00, 8'h01, 0, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      txn(k, 1'b0, 8'hFF, 8'h00, 1, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      post(k, "rd_ff", 32'(rd), 32'h7E);
      txn(k, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      post(k, "rd_00", 32'(rd), 32'h01);
      // Reset while a write is waiting: abandoned and memory cleared.
      req_valid[k] = 1'b1; req_write[k] = 1'b1; req_addr[k] = 8'h20; req_wdata[k] = 8'h3C;
      while (!req_ready[k]) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      post(k, "wait_busy", 32'(busy[k]), 32'd1);
      #1 rst[k] = 1'b1;
      #1 post(k, "abort_busy", 32'(busy[k]), 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      rst[k] = 1'b0;
      txn(k, 1'b0, 8'h20, 8'h00, 0, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      post(k, "abort_rd20", 32'(rd), 32'h00);
      txn(k, 1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0, 8'h00, rd, ra, rw, lat);
      post(k, "abort_rd10", 32'(rd), 32'h00);
      // Random traffic against the model.
      for (int i = 0; i < nrand; i++) begin
         txn(k, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
             8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 8'h00,
             rd, ra, rw, lat);
      end
      req_valid[k] = 1'b0;
   endtask

   initial begin
      rst = 3'b111; req_valid = 3'b000; req_write = 3'b000; rsp_ready = 3'b000;
      for (int k = 0; k < 3; k++) begin
         req_addr[k] = 8'h00;
         req_wdata[k] = 8'h00;
      end
      run_inst(0, 150);
      run_inst(1, 30);
      run_inst(2, 30);
      repeat (3) @(negedge clk);
      #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
